// File: rtl/multi_slave_bus_controller.sv
// Registered multi-slave bus controller: decodes a processor address into one of NUM_SLAVES regions,
// rebases it, and runs one transfer at a time, reporting unmapped-address and timeout errors.
module multi_slave_bus_controller #(
    parameter int                       DATA_WIDTH     = 64,
    parameter int                       ADDR_WIDTH     = 64,
    parameter int                       NUM_SLAVES     = 4,
    parameter int                       REGION_SHIFT   = 24,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'd3, 32'd2, 32'd1, 32'd0},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_LIMIT    = {32'd6, 32'd5, 32'd4, 32'd0},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             transfer_enable,
    input  logic [DATA_WIDTH/8-1:0]          byte_write_enable,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             transfer_busy,
    output logic                             transfer_error,
    output logic [NUM_SLAVES-1:0]            slave_enable,
    output logic [DATA_WIDTH/8-1:0]          slave_byte_write_enable,
    output logic [ADDR_WIDTH-1:0]            slave_address,
    output logic [DATA_WIDTH-1:0]            slave_write_data,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
    input  logic [NUM_SLAVES-1:0]            slave_busy
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int RGN_W  = ADDR_WIDTH - REGION_SHIFT;
    localparam int CMP_W  = (RGN_W > 32) ? RGN_W : 32;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Inclusive range test, widened so region indices wider than 32 bits compare correctly.
    function automatic logic region_in(input logic [RGN_W-1:0] rgn,
                                       input logic [31:0]      lo,
                                       input logic [31:0]      hi);
        logic [CMP_W-1:0] r_v;
        logic [CMP_W-1:0] lo_v;
        logic [CMP_W-1:0] hi_v;
        r_v  = CMP_W'(rgn);
        lo_v = CMP_W'(lo);
        hi_v = CMP_W'(hi);
        return (r_v >= lo_v) && (r_v <= hi_v);
    endfunction

    logic [1:0]            state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STRB_W-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [NUM_SLAVES-1:0] en_q, en_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [RGN_W-1:0]      region_s;
    logic                  hit_s;
    logic [SEL_W-1:0]      hit_sel_s;
    logic [ADDR_WIDTH-1:0] hit_base_s;
    logic                  sel_busy_s;
    logic [DATA_WIDTH-1:0] sel_rdata_s;

    // Region decode; scanning from the top index down lets the lowest overlapping slave win.
    always_comb begin
        region_s   = mem_address[ADDR_WIDTH-1:REGION_SHIFT];
        hit_s      = 1'b0;
        hit_sel_s  = '0;
        hit_base_s = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region_in(region_s, SLAVE_BASE[32*i +: 32], SLAVE_LIMIT[32*i +: 32])) begin
                hit_s      = 1'b1;
                hit_sel_s  = SEL_W'(i);
                hit_base_s = ADDR_WIDTH'(SLAVE_BASE[32*i +: 32]) << REGION_SHIFT;
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Response mux for the latched slave.
    always_comb begin
        sel_busy_s  = 1'b0;
        sel_rdata_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_busy_s  = slave_busy[i];
                sel_rdata_s = slave_read_data[DATA_WIDTH*i +: DATA_WIDTH];
            end else begin
                sel_busy_s  = sel_busy_s;
            end
        end
    end

    // Transfer FSM next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        en_d    = en_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                en_d = '0;
                if (transfer_enable) begin
                    if (hit_s) begin
                        sel_d   = hit_sel_s;
                        addr_d  = mem_address - hit_base_s;
                        be_d    = byte_write_enable;
                        wd_d    = write_data;
                        cnt_d   = 16'd0;
                        en_d    = NUM_SLAVES'(1'b1) << hit_sel_s;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (!sel_busy_s) begin
                    rdata_d = sel_rdata_s;
                    err_d   = 1'b0;
                    en_d    = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    en_d    = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                en_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                en_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer and drops slave_enable at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            en_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign transfer_busy           = ((state_q == ST_IDLE) && transfer_enable) || (state_q == ST_ACCESS);
    assign read_data               = rdata_q;
    assign transfer_error          = err_q;
    assign slave_enable            = en_q;
    assign slave_byte_write_enable = be_q;
    assign slave_address           = addr_q;
    assign slave_write_data        = wd_q;

endmodule

// File: tb/tb_multi_slave_bus_controller.sv
// Randomised scoreboard bench for multi_slave_bus_controller (2 slaves, regions {0},{1..4}, timeout 16).
module tb_multi_slave_bus_controller;

    localparam int T = 16;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          en_cyc;
        logic [1:0]  en_mask;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        transfer_enable;
    logic [7:0]  byte_write_enable;
    logic [63:0] write_data;
    logic [63:0] mem_address;
    logic [63:0] read_data;
    logic        transfer_busy;
    logic        transfer_error;
    logic [1:0]  slave_enable;
    logic [7:0]  slave_byte_write_enable;
    logic [63:0] slave_address;
    logic [63:0] slave_write_data;
    logic [1:0]  sl_busy;
    logic [63:0] srd [2];
    int          wait_req [2];
    int          en_cnt [2];

    logic        ov_en;
    logic [63:0] ov_addr;
    logic [63:0] ov_rd;
    logic        ov_busy;
    logic        ov_err;
    logic [1:0]  ov_sen;
    logic [7:0]  ov_sbe;
    logic [63:0] ov_saddr;
    logic [63:0] ov_swd;

    longint unsigned base_t [2] = '{64'd0, 64'd1};
    longint unsigned lim_t  [2] = '{64'd0, 64'd4};

    exp_t        exp_q [$];
    string       dname_q [$];
    logic [63:0] dact_q [$];
    logic [63:0] dexp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    multi_slave_bus_controller #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .NUM_SLAVES(2), .REGION_SHIFT(24),
        .SLAVE_BASE({32'd1, 32'd0}), .SLAVE_LIMIT({32'd4, 32'd0}), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset_n(reset_n), .transfer_enable(transfer_enable),
        .byte_write_enable(byte_write_enable), .write_data(write_data), .mem_address(mem_address),
        .read_data(read_data), .transfer_busy(transfer_busy), .transfer_error(transfer_error),
        .slave_enable(slave_enable), .slave_byte_write_enable(slave_byte_write_enable),
        .slave_address(slave_address), .slave_write_data(slave_write_data),
        .slave_read_data({srd[1], srd[0]}), .slave_busy(sl_busy)
    );

    multi_slave_bus_controller #(
        .DATA_WIDTH(64), .ADDR_WIDTH(64), .NUM_SLAVES(2), .REGION_SHIFT(24),
        .SLAVE_BASE({32'd0, 32'd0}), .SLAVE_LIMIT({32'd0, 32'd0}), .TIMEOUT_CYCLES(T)
    ) u_ovl (
        .clock(clock), .reset_n(reset_n), .transfer_enable(ov_en),
        .byte_write_enable(8'h00), .write_data(64'h0), .mem_address(ov_addr),
        .read_data(ov_rd), .transfer_busy(ov_busy), .transfer_error(ov_err),
        .slave_enable(ov_sen), .slave_byte_write_enable(ov_sbe),
        .slave_address(ov_saddr), .slave_write_data(ov_swd),
        .slave_read_data({64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5}), .slave_busy(2'b00)
    );

    // Slave model: busy for wait_req cycles of enable, then ready.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) en_cnt[i] <= slave_enable[i] ? en_cnt[i] + 1 : 0;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) sl_busy[i] = slave_enable[i] && (en_cnt[i] < wait_req[i]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic dchk(input string name, input logic [63:0] act, input logic [63:0] exp);
        dname_q.push_back(name);
        dact_q.push_back(act);
        dexp_q.push_back(exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: performs every comparison; pops the scoreboard when a response cycle appears.
    initial begin : monitor
        bit          prev_busy = 1'b0;
        bit          bad = 1'b0;
        int          lat = 0;
        int          en_cyc = 0;
        logic [1:0]  obs_en = 2'b00;
        logic [63:0] obs_addr = 64'h0;
        logic [7:0]  obs_be = 8'h00;
        logic [63:0] obs_wd = 64'h0;
        exp_t        e;
        forever begin
            @(negedge clock);
            while (dname_q.size() > 0) chk(dname_q.pop_front(), dact_q.pop_front(), dexp_q.pop_front());
            if (!reset_n) begin
                prev_busy = 1'b0; lat = 0; en_cyc = 0; bad = 1'b0;
            end else begin
                if (transfer_busy) lat++;
                if (slave_enable != 2'b00) begin
                    if (en_cyc == 0) begin
                        obs_en = slave_enable; obs_addr = slave_address;
                        obs_be = slave_byte_write_enable; obs_wd = slave_write_data;
                    end else if (slave_enable !== obs_en || slave_address !== obs_addr ||
                                 slave_byte_write_enable !== obs_be || slave_write_data !== obs_wd) begin
                        bad = 1'b1;
                    end
                    if (!transfer_busy || $countones(slave_enable) != 1) bad = 1'b1;
                    en_cyc++;
                end
                if (prev_busy && !transfer_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("read_data", read_data, e.rdata);
                        chk("transfer_error", 64'(transfer_error), 64'(e.err));
                        chk("latency", 64'(lat), 64'(e.lat));
                        chk("enable_cycles", 64'(en_cyc), 64'(e.en_cyc));
                        chk("enable_onehot_stable", 64'(bad), 64'd0);
                        if (e.en_cyc > 0) begin
                            chk("enable_mask", 64'(obs_en), 64'(e.en_mask));
                            chk("slave_address", obs_addr, e.addr);
                            chk("slave_strobes", 64'(obs_be), 64'(e.be));
                            chk("slave_write_data", obs_wd, e.wd);
                        end
                    end
                    lat = 0; en_cyc = 0; bad = 1'b0;
                end
                prev_busy = transfer_busy;
            end
        end
    end

    // One transfer: model the expected outcome, push it, then drive the request.
    // gap==0 presents the request in the RESP cycle of the previous transfer.
    task automatic do_xfer(input logic [63:0] a, input logic [7:0] be, input logic [63:0] wd,
                           input int wt, input logic [63:0] rd, input int gap);
        exp_t e;
        int   s;
        int   acc;
        int   n;
        s = -1;
        for (int i = 0; i < 2; i++)
            if (s < 0 && (a >> 24) >= base_t[i] && (a >> 24) <= lim_t[i]) s = i;
        repeat (gap) step();
        if (s >= 0) begin
            acc       = (wt >= T) ? T : wt + 1;
            e.rdata   = (wt >= T) ? 64'h0 : rd;
            e.err     = (wt >= T);
            e.lat     = 1 + acc;
            e.en_cyc  = acc;
            e.en_mask = 2'b01 << s;
            e.addr    = a - (base_t[s] << 24);
            wait_req[s] = wt;     srd[s] = rd;
            wait_req[1-s] = 0;    srd[1-s] = ~rd;
        end else begin
            e.rdata = 64'h0; e.err = 1'b1; e.lat = 1; e.en_cyc = 0; e.en_mask = 2'b00; e.addr = 64'h0;
            srd[0] = rd; srd[1] = ~rd;
        end
        e.be = be;
        e.wd = wd;
        exp_q.push_back(e);
        mem_address = a; byte_write_enable = be; write_data = wd; transfer_enable = 1'b1;
        step();
        if (gap == 0) step();
        transfer_enable   = 1'b0;
        mem_address       = {$urandom, $urandom};
        byte_write_enable = 8'($urandom);
        write_data        = {$urandom, $urandom};
        n = 0;
        while (transfer_busy && n < 100) begin
            step();
            n++;
        end
        dchk("resp_within_bound", 64'(n < 100), 64'd1);
    endtask

    initial begin : driver
        logic [63:0] a;
        int          wt;
        reset_n = 1'b0; transfer_enable = 1'b0; byte_write_enable = 8'h00;
        write_data = 64'h0; mem_address = 64'h0; ov_en = 1'b0; ov_addr = 64'h0;
        srd[0] = 64'h0; srd[1] = 64'h0; wait_req[0] = 0; wait_req[1] = 0;
        repeat (3) step();
        dchk("reset_read_data", read_data, 64'h0);
        dchk("reset_error", 64'(transfer_error), 64'd0);
        dchk("reset_enable", 64'(slave_enable), 64'd0);
        dchk("reset_address", slave_address, 64'h0);
        dchk("reset_busy", 64'(transfer_busy), 64'd0);
        reset_n = 1'b1;
        step();

        // Overlapping regions: slave 0 must win.
        ov_addr = 64'h8; ov_en = 1'b1;
        step();
        ov_en = 1'b0;
        dchk("overlap_enable", 64'(ov_sen), 64'd1);
        dchk("overlap_address", ov_saddr, 64'h8);
        step();
        dchk("overlap_read_data", ov_rd, 64'hA5A5_A5A5_A5A5_A5A5);
        dchk("overlap_error", 64'(ov_err), 64'd0);
        dchk("overlap_resp_busy", 64'(ov_busy), 64'd0);

        do_xfer(64'h0000_0000_0000_0010, 8'h00, 64'h0, 0, 64'hDEAD_BEEF_0000_0001, 1);
        do_xfer(64'h0000_0000_0200_0008, 8'hFF, 64'h1234, 3, 64'h0BAD_F00D_0000_0002, 1);
        do_xfer(64'h0000_0000_0500_0000, 8'h00, 64'h0, 0, 64'h1111_2222_3333_4444, 1);
        do_xfer(64'h0000_0000_0100_0000, 8'h00, 64'h0, 1000, 64'h5555_6666_7777_8888, 1);
        do_xfer(64'h0000_0000_0000_0020, 8'h00, 64'h0, 0, 64'h9999_AAAA_BBBB_CCCC, 0);
        do_xfer(64'h0000_0000_04FF_FFF8, 8'h0F, 64'h77, T - 1, 64'h1357_9BDF_0246_8ACE, 1);

        for (int k = 0; k < 80; k++) begin
            a = (64'($urandom_range(0, 7)) << 24) | 64'($urandom_range(0, 24'hFF_FFFF));
            if ($urandom_range(0, 7) == 0) a[63] = 1'b1;
            case ($urandom_range(0, 9))
                0:       wt = T - 1;
                1:       wt = T;
                2:       wt = 1000;
                default: wt = $urandom_range(0, 4);
            endcase
            do_xfer(a, 8'($urandom), {$urandom, $urandom}, wt, {$urandom, $urandom}, $urandom_range(0, 2));
        end

        // Reset during the second ACCESS cycle of a slow write.
        step();
        wait_req[1] = 3; srd[1] = 64'hFEED;
        mem_address = 64'h0000_0000_0200_0008; byte_write_enable = 8'hFF;
        write_data = 64'h1234; transfer_enable = 1'b1;
        step();
        transfer_enable = 1'b0;
        step();
        dchk("pre_reset_enable", 64'(slave_enable), 64'd2);
        reset_n = 1'b0;
        #1;
        dchk("async_reset_enable", 64'(slave_enable), 64'd0);
        dchk("async_reset_strobes", 64'(slave_byte_write_enable), 64'd0);
        dchk("async_reset_address", slave_address, 64'h0);
        dchk("async_reset_wdata", slave_write_data, 64'h0);
        dchk("async_reset_read_data", read_data, 64'h0);
        dchk("async_reset_error", 64'(transfer_error), 64'd0);
        dchk("async_reset_busy", 64'(transfer_busy), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        dchk("post_reset_busy", 64'(transfer_busy), 64'd0);
        dchk("post_reset_enable", 64'(slave_enable), 64'd0);
        do_xfer(64'h0000_0000_0300_0040, 8'h00, 64'h0, 1, 64'hCAFE_0000_BEEF_0001, 1);

        repeat (3) step();
        dchk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
